sys_bridge_hs: RTL and testbench
================================

Name: sys_bridge_hs

Overview:
- Parametrised, handshaked successor to the single-cycle system bridge. Sits between the CPU memory stage and up to 8 memory-mapped slaves (DM, timer, UART, switches, LEDs, tubes, ...).
- Decodes each request against per-slave base/limit windows, drives exactly one slave with a local offset address, and waits for that slave's ready, bounded by a timeout.
- Returns one response per request, with an error flag for unmapped, misaligned or timed-out accesses.
- Holds at most one outstanding transaction.

Parameters:
- NUM_DEV, 7, number of slave slots (1..8).
- DEV_BASE, {7'h..}, flat NUM_DEV*32-bit vector; slot k occupies bits [32k+31:32k]. Default slots 0..6 = 0x0000_0000, 0x0000_7F00, 0x0000_7F20, 0x0000_7F40, 0x0000_7F50, 0x0000_7F58, 0x0000_7F60.
- DEV_LIMIT, {..}, flat NUM_DEV*32-bit inclusive upper bounds. Default slots 0..6 = 0x2FFF, 0x7F0B, 0x7F3B, 0x7F47, 0x7F57, 0x7F5B, 0x7F63.
- TIMEOUT, 16, maximum number of ACCESS cycles before an error response (≥1).

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- req_valid, input, 1, CPU request present.
- req_ready, output, 1, bridge can accept a request this cycle.
- req_we, input, 1, 1 = write, 0 = read.
- req_addr, input, 32, byte address.
- req_wdata, input, 32, write data.
- req_be, input, 4, byte enables.
- resp_valid, output, 1, one-cycle response pulse.
- resp_rdata, output, 32, read data; 0 for writes and errors.
- resp_err, output, 1, error qualifier, valid with resp_valid.
- dev_sel, output, NUM_DEV, one-hot slave select.
- dev_we, output, 1, write strobe, qualified by dev_sel.
- dev_addr, output, 32, latched address minus the selected slot's base.
- dev_wdata, output, 32, latched write data.
- dev_be, output, 4, latched byte enables.
- dev_rdata, input, NUM_DEV*32, flat slave read data; slot k at [32k+31:32k].
- dev_ready, input, NUM_DEV, per-slave completion.
- err_cnt, output, 8, saturating count of error responses.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, dev_sel=0, dev_we=0, dev_addr=0, dev_wdata=0, dev_be=0, err_cnt=0.
  - req_ready rises at the first clk edge after reset release.
- States: IDLE, ACCESS, RESP. req_ready=1 only in IDLE.
- IDLE, on req_valid:
  - Latch we/addr/wdata/be. Decode hit[k] = (addr ≥ BASE_k) && (addr ≤ LIMIT_k); the lowest k wins on overlap.
  - If addr[1:0]≠0 or there is no hit: go to RESP with resp_err=1 and resp_rdata=0. No dev_sel is ever asserted.
  - Otherwise: go to ACCESS with slot k registered, and timeout counter=0.
- ACCESS:
  - dev_sel[k]=1 and dev_we=latched we; dev_addr/wdata/be are stable for the whole state.
  - Each cycle, sample dev_ready[k]. Ready from unselected slaves is ignored.
  - If dev_ready[k]=1: capture dev_rdata slice k (reads) or 0 (writes), resp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: resp_err=1, resp_rdata=0, go to RESP.
  - Else: counter+1.
  - Ready arriving on the same cycle as the timeout wins (no error).
- RESP:
  - resp_valid=1 for exactly one cycle with registered rdata/err. dev_sel=0.
  - Return to IDLE. Back-to-back requests are therefore spaced by at least one idle-accept cycle.
- Latency:
  - Zero-wait slave: accept at edge 0, ACCESS in cycle 1, resp_valid in cycle 2.
  - Unmapped or misaligned: resp_valid in cycle 1.
  - Timeout: resp_valid TIMEOUT+1 cycles after accept.
- err_cnt: +1 on every resp_valid with resp_err=1. Saturates at 255, no wrap.
- Reset mid-ACCESS: dev_sel drops immediately, no response is issued, and the transaction is lost.
- req_valid outside IDLE is ignored; the CPU must hold the request until req_ready.

Test Plan:
- Read 0x0000_1004, slot 0 dev_ready=1 immediately, dev_rdata[31:0]=0xDEADBEEF -> dev_sel=0b0000001 and dev_addr=0x1004 in cycle 1; resp_valid with rdata=0xDEADBEEF and err=0 in cycle 2.
- Write 0x0000_7F24, wdata 0x55, be=0xF, slot 2 ready after 3 cycles -> dev_sel[2]=1 and dev_we=1 for 3 cycles, dev_addr=0x4; resp err=0, rdata=0; err_cnt unchanged.
- Read 0x0000_5000 (unmapped) and read 0x0000_7F02 (misaligned) -> each gives resp_valid one cycle after accept with err=1, dev_sel never asserted; err_cnt=2.
- Read 0x0000_7F50 with slot 4 never ready, TIMEOUT=16 -> dev_sel[4] high for exactly 16 cycles; resp err=1, rdata=0.
- Assert reset during ACCESS -> dev_sel=0 immediately, no resp_valid; after release, req_ready=1 one edge later and a fresh slot-0 read completes normally.
- Issue 300 unmapped requests -> err_cnt reads 255 and holds.

Source files
------------

// File: rtl/sys_bridge_hs.sv
// Handshaked system bridge: decodes a CPU request onto one of NUM_DEV memory-mapped
// slaves, waits for that slave's ready (bounded by TIMEOUT) and returns one response.
module sys_bridge_hs #(
    parameter int NUM_DEV = 7,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE = {
        32'h0000_7F60, 32'h0000_7F58, 32'h0000_7F50, 32'h0000_7F40,
        32'h0000_7F20, 32'h0000_7F00, 32'h0000_0000},
    parameter logic [NUM_DEV*32-1:0] DEV_LIMIT = {
        32'h0000_7F63, 32'h0000_7F5B, 32'h0000_7F57, 32'h0000_7F47,
        32'h0000_7F3B, 32'h0000_7F0B, 32'h0000_2FFF},
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [3:0]           req_be,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [NUM_DEV-1:0]   dev_sel,
    output logic                 dev_we,
    output logic [31:0]          dev_addr,
    output logic [31:0]          dev_wdata,
    output logic [3:0]           dev_be,
    input  logic [NUM_DEV*32-1:0] dev_rdata,
    input  logic [NUM_DEV-1:0]   dev_ready,
    output logic [7:0]           err_cnt
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic                 req_ready_r, resp_valid_r, resp_err_r, dev_we_r, we_r;
    logic [31:0]          resp_rdata_r, dev_addr_r, dev_wdata_r;
    logic [3:0]           dev_be_r;
    logic [NUM_DEV-1:0]   dev_sel_r;
    logic [7:0]           err_cnt_r;
    logic [2:0]           slot_r;
    logic [CW-1:0]        cnt_r;

    logic                 hit_s, bad_s, accept_s, sel_ready_s, timeout_s;
    logic [2:0]           hit_idx_s;
    logic [31:0]          hit_base_s, sel_rdata_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    function automatic logic [NUM_DEV-1:0] onehot(input logic [2:0] idx);
        logic [NUM_DEV-1:0] r;
        r = {NUM_DEV{1'b0}};
        for (int k = 0; k < NUM_DEV; k++) begin
            r[k] = (idx == 3'(k));
        end
        return r;
    endfunction

    // Window decode; scanning downward lets the lowest matching slot win.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = 3'd0;
        hit_base_s = 32'h0000_0000;
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            if ((req_addr >= DEV_BASE[k*32 +: 32]) && (req_addr <= DEV_LIMIT[k*32 +: 32])) begin
                hit_s      = 1'b1;
                hit_idx_s  = 3'(k);
                hit_base_s = DEV_BASE[k*32 +: 32];
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    // Pick out ready and read data of the registered slot only.
    always_comb begin
        sel_ready_s = 1'b0;
        sel_rdata_s = 32'h0000_0000;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (slot_r == 3'(k)) begin
                sel_ready_s = dev_ready[k];
                sel_rdata_s = dev_rdata[k*32 +: 32];
            end else begin
                sel_ready_s = sel_ready_s;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s   = state_r;
        accept_s  = (state_r == ST_IDLE) && req_ready_r && req_valid;
        bad_s     = (req_addr[1:0] != 2'b00) || !hit_s;
        timeout_s = (cnt_r == TO_LAST);
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = bad_s ? ST_RESP : ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (sel_ready_s || timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, slave bus and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            dev_sel_r    <= {NUM_DEV{1'b0}};
            dev_we_r     <= 1'b0;
            dev_addr_r   <= 32'h0000_0000;
            dev_wdata_r  <= 32'h0000_0000;
            dev_be_r     <= 4'h0;
            err_cnt_r    <= 8'h00;
            we_r         <= 1'b0;
            slot_r       <= 3'd0;
            cnt_r        <= {CW{1'b0}};
        end else begin
            state_r      <= state_s;
            req_ready_r  <= (state_s == ST_IDLE);
            resp_valid_r <= (state_s == ST_RESP);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        we_r        <= req_we;
                        dev_addr_r  <= req_addr - hit_base_s;
                        dev_wdata_r <= req_wdata;
                        dev_be_r    <= req_be;
                        slot_r      <= hit_idx_s;
                        cnt_r       <= {CW{1'b0}};
                        if (bad_s) begin
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                            err_cnt_r    <= sat_inc(err_cnt_r);
                        end else begin
                            dev_sel_r <= onehot(hit_idx_s);
                            dev_we_r  <= req_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready_s) begin
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= we_r ? 32'h0000_0000 : sel_rdata_s;
                        dev_sel_r    <= {NUM_DEV{1'b0}};
                        dev_we_r     <= 1'b0;
                    end else if (timeout_s) begin
                        resp_err_r   <= 1'b1;
                        resp_rdata_r <= 32'h0000_0000;
                        dev_sel_r    <= {NUM_DEV{1'b0}};
                        dev_we_r     <= 1'b0;
                        err_cnt_r    <= sat_inc(err_cnt_r);
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                end
                default: begin
                    dev_sel_r <= {NUM_DEV{1'b0}};
                    dev_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign dev_sel    = dev_sel_r;
    assign dev_we     = dev_we_r;
    assign dev_addr   = dev_addr_r;
    assign dev_wdata  = dev_wdata_r;
    assign dev_be     = dev_be_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_sys_bridge_hs.sv
// Table-driven bench for sys_bridge_hs with a per-slot latency slave model and a
// response scoreboard queue.
module tb_sys_bridge_hs;

    localparam int ND = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic [3:0]        req_be = 4'h0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ND-1:0]     dev_sel;
    logic              dev_we;
    logic [31:0]       dev_addr;
    logic [31:0]       dev_wdata;
    logic [3:0]        dev_be;
    logic [ND*32-1:0]  dev_rdata = '0;
    logic [ND-1:0]     dev_ready;
    logic [7:0]        err_cnt;

    sys_bridge_hs dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_be(dev_be),
        .dev_rdata(dev_rdata), .dev_ready(dev_ready), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Slave model: the target slot answers once it has been selected lat_cur+1 cycles;
    // noise_cur drives ready on other slots, which the bridge must ignore.
    logic [7:0]    acc_cnt = 8'd0;
    logic [7:0]    lat_cur = 8'd0;
    logic [2:0]    slot_cur = 3'd0;
    logic [ND-1:0] noise_cur = '0;
    logic [ND-1:0] tgt_mask;

    always @(posedge clk) begin
        if (dev_sel != '0) acc_cnt <= acc_cnt + 8'd1;
        else               acc_cnt <= 8'd0;
    end

    assign tgt_mask  = ND'(1) << slot_cur;
    assign dev_ready = noise_cur | (dev_sel & tgt_mask & {ND{(acc_cnt >= lat_cur)}});

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [2:0]  slot;
        logic [7:0]  lat;      // 8'hFF = never ready
        logic [6:0]  noise;
        logic [31:0] rd;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_daddr;
        logic [7:0]  exp_lat;
        logic [7:0]  exp_selc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t  vecs [12];
    exp_t  sb [$];
    int    errs = 0;
    int    checks = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v);
        int   cyc;
        int   selc;
        int   w;
        bit   got;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            checks++; errs++;
            $display("FAIL req_ready_wait: never ready within 50 cycles");
        end
        for (int k = 0; k < ND; k++) dev_rdata[k*32 +: 32] = 32'hBAD0_0000 | 32'(k);
        dev_rdata[int'(v.slot)*32 +: 32] = v.rd;
        slot_cur  = v.slot;
        lat_cur   = v.lat;
        noise_cur = v.noise;
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(posedge clk);
        cyc = 0; selc = 0; got = 1'b0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            if (dev_sel != '0) begin
                selc++;
                check("dev_sel", 32'(dev_sel), 32'(ND'(1) << v.slot));
                check("dev_addr", dev_addr, v.exp_daddr);
                check("dev_ctl", {dev_we, dev_be, 27'd0}, {v.we, v.be, 27'd0});
                if (v.we) check("dev_wdata", dev_wdata, v.wdata);
            end
            if (resp_valid) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL scoreboard: response with empty queue");
                end else begin
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 32'(resp_err), 32'(e.err));
                end
            end
        end
        if (!got) begin
            checks++; errs++;
            $display("FAIL resp_timeout: no resp_valid within 64 cycles");
            sb.delete();
        end
        check("resp_latency", 32'(cyc), 32'(v.exp_lat));
        check("sel_cycles", 32'(selc), 32'(v.exp_selc));
        if (v.exp_err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        @(negedge clk);
        check("resp_pulse", 32'(resp_valid), 32'd0);
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
    endtask

    initial begin
        vec_t bad_v;
        int   n;
        //           we    addr           wdata          be    slot  lat    noise        rd             err   rdata          daddr          lat   selc
        vecs[0]  = '{1'b0, 32'h0000_1004, 32'h0,         4'hF, 3'd0, 8'd0,  7'b0000000, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 32'h0000_1004, 8'd2,  8'd1};
        vecs[1]  = '{1'b1, 32'h0000_7F24, 32'h0000_0055, 4'hF, 3'd2, 8'd2,  7'b0000000, 32'h1111_2222, 1'b0, 32'h0,         32'h0000_0004, 8'd4,  8'd3};
        vecs[2]  = '{1'b0, 32'h0000_5000, 32'h0,         4'hF, 3'd0, 8'd0,  7'b0000000, 32'h0,         1'b1, 32'h0,         32'h0,         8'd1,  8'd0};
        vecs[3]  = '{1'b0, 32'h0000_7F02, 32'h0,         4'hF, 3'd1, 8'd0,  7'b0000000, 32'h3333_4444, 1'b1, 32'h0,         32'h0,         8'd1,  8'd0};
        vecs[4]  = '{1'b0, 32'h0000_7F50, 32'h0,         4'hF, 3'd4, 8'hFF, 7'b1101111, 32'h5555_6666, 1'b1, 32'h0,         32'h0,         8'd17, 8'd16};
        vecs[5]  = '{1'b0, 32'h0000_2FFC, 32'h0,         4'hF, 3'd0, 8'd1,  7'b0000000, 32'h1234_5678, 1'b0, 32'h1234_5678, 32'h0000_2FFC, 8'd3,  8'd2};
        vecs[6]  = '{1'b0, 32'h0000_3000, 32'h0,         4'hF, 3'd0, 8'd0,  7'b0000000, 32'h0,         1'b1, 32'h0,         32'h0,         8'd1,  8'd0};
        vecs[7]  = '{1'b0, 32'h0000_7F60, 32'h0,         4'hF, 3'd6, 8'd0,  7'b0111111, 32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 32'h0,         8'd2,  8'd1};
        vecs[8]  = '{1'b0, 32'h0000_7F38, 32'h0,         4'hF, 3'd2, 8'd15, 7'b0000000, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 32'h0000_0018, 8'd17, 8'd16};
        vecs[9]  = '{1'b0, 32'h0000_7F0C, 32'h0,         4'hF, 3'd1, 8'd0,  7'b0000000, 32'h0,         1'b1, 32'h0,         32'h0,         8'd1,  8'd0};
        vecs[10] = '{1'b1, 32'h0000_7F44, 32'h0000_1234, 4'h3, 3'd3, 8'd0,  7'b0000000, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0000_0004, 8'd2,  8'd1};
        vecs[11] = '{1'b0, 32'h0000_7F08, 32'h0,         4'hF, 3'd1, 8'd3,  7'b0000000, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 32'h0000_0008, 8'd5,  8'd4};

        // Reset state and first-edge req_ready.
        #1;
        check("rst_outputs", {req_ready, resp_valid, resp_err, dev_we, dev_be, 7'(dev_sel), 17'd0},
              {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 7'd0, 17'd0});
        check("rst_bus", resp_rdata | dev_addr | dev_wdata | 32'(err_cnt), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_edge", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) run_req(vecs[i]);

        // Reset during ACCESS: select drops at once, no response, fresh read afterwards.
        @(negedge clk);
        slot_cur = 3'd4; lat_cur = 8'hFF; noise_cur = '0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_7F50; req_be = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_access_sel", 32'(dev_sel), 32'h10);
        reset = 1'b0;
        #1 check("rst_sel_drop", 32'(dev_sel), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        exp_cnt = 8'd0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        reset = 1'b1;
        #1 check("rel_ready_low", 32'(req_ready), 32'd0);
        check("rst_no_resp", 32'(n), 32'd0);
        @(negedge clk);
        check("rel_ready_high", 32'(req_ready), 32'd1);
        run_req(vecs[0]);

        // Saturating error counter.
        bad_v = vecs[2];
        for (int i = 0; i < 300; i++) run_req(bad_v);
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
        repeat (3) @(negedge clk);
        check("err_cnt_hold", 32'(err_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
